// File: rtl/seq_multiplier_pkg.sv
// Shared multiplier definitions: controller state encoding and the fixed
// latency the execute state machine uses to schedule exec2.
package seq_multiplier_pkg;

  // Operand width used by the ALU datapath.
  localparam int unsigned MUL_WIDTH = 16;

  // Cycles from the start edge to the completion edge; one iteration per bit.
  localparam int unsigned MUL_LATENCY = MUL_WIDTH;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/result bundle between the ALU and the iterative multiplier.
interface seq_multiplier_if
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
);
  logic                 start;
  logic [WIDTH-1:0]     mul1;
  logic [WIDTH-1:0]     mul2;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   mulresult;

  // ALU side issues operands and watches for completion.
  modport master (
    output start, mul1, mul2,
    input  busy, done, mulresult
  );

  // Multiplier side.
  modport slave (
    input  start, mul1, mul2,
    output busy, done, mulresult
  );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier with a fixed WIDTH-cycle latency.
// The partial product lives in prod_q; mulresult_q only changes on the
// completion edge, so partial sums are never visible on the output.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input logic             clk,
  input logic             rst,
  seq_multiplier_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_e           state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mulresult_q, mulresult_d;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod_next;

  // One iteration: conditional add into the upper half with carry kept,
  // then shift {carry, upper, lower} right by one.
  always_comb begin
    sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_next = {sum, prod_q[WIDTH-1:1]};
  end

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    mulresult_d = mulresult_q;
    unique case (state_q)
      MUL_IDLE, MUL_DONE: begin
        if (bus.start) begin
          mcand_d = bus.mul1;
          prod_d  = {{WIDTH{1'b0}}, bus.mul2};
          cnt_d   = '0;
          state_d = MUL_RUN;
        end else begin
          state_d = MUL_IDLE;
        end
      end
      MUL_RUN: begin
        prod_d = prod_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          mulresult_d = prod_next;
          state_d     = MUL_DONE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MUL_IDLE;
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      mulresult_q <= '0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      mulresult_q <= mulresult_d;
    end
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    bus.busy      = (state_q == MUL_RUN);
    bus.done      = (state_q == MUL_DONE);
    bus.mulresult = mulresult_q;
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier against an arithmetic model:
// product = a*b, completion exactly MUL_LATENCY edges after the start edge,
// result held between completions.
module tb_seq_multiplier;
  import seq_multiplier_pkg::*;

  localparam int unsigned W = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [2*W-1:0] held;   // model of the value mulresult must be showing

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic eb, input logic ed, input logic [2*W-1:0] er);
    chk({tag, ".busy"}, 64'(bus.busy), 64'(eb));
    chk({tag, ".done"}, 64'(bus.done), 64'(ed));
    chk({tag, ".mulresult"}, 64'(bus.mulresult), 64'(er));
  endtask

  function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[2*W-1:0];
  endfunction

  // Single operation; optionally re-pulse start with other operands mid-run.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int pulse_at);
    logic [2*W-1:0] exp;
    exp = model_mul(a, b);
    bus.mul1  = a;
    bus.mul2  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.mul1  = W'($urandom);
    bus.mul2  = W'($urandom);
    chk_out({tag, ".c0"}, 1'b1, 1'b0, held);
    for (int k = 1; k < int'(MUL_LATENCY); k++) begin
      if (k == pulse_at) begin
        bus.start = 1'b1;
        bus.mul1  = W'(2);
        bus.mul2  = W'(2);
      end
      tick();
      bus.start = 1'b0;
      bus.mul1  = W'($urandom);
      bus.mul2  = W'($urandom);
      chk_out({tag, ".run"}, 1'b1, 1'b0, held);
    end
    tick();
    held = exp;
    chk_out({tag, ".done"}, 1'b0, 1'b1, held);
    tick();
    chk_out({tag, ".idle"}, 1'b0, 1'b0, held);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    held      = '0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mul1  = '0;
    bus.mul2  = '0;
    tick();
    tick();
    chk_out("reset", 1'b0, 1'b0, '0);
    rst = 1'b0;
    tick();
    chk_out("post_reset", 1'b0, 1'b0, '0);

    // Directed cases.
    do_op("3x5",       W'(3),      W'(5),      -1);
    chk("3x5.value", 64'(held), 64'h0000_000F);
    do_op("ffffxffff", W'('hFFFF), W'('hFFFF), -1);
    chk("ffff.value", 64'(held), 64'hFFFE_0001);
    do_op("8000x2",    W'('h8000), W'(2),      -1);
    do_op("0x1234",    W'(0),      W'('h1234), -1);
    do_op("1xabcd",    W'(1),      W'('hABCD), -1);
    do_op("start_in_run", W'(7),   W'(9),      5);
    chk("start_in_run.value", 64'(held), 64'h0000_003F);
    repeat (3) begin
      tick();
      chk_out("no_second_op", 1'b0, 1'b0, held);
    end

    // Back-to-back: start held high across the completion cycle.
    bus.mul1  = W'(7);
    bus.mul2  = W'(9);
    bus.start = 1'b1;
    tick();
    bus.mul1 = W'('h0100);
    bus.mul2 = W'('h0100);
    chk_out("b2b.c0", 1'b1, 1'b0, held);
    repeat (MUL_LATENCY - 1) begin
      tick();
      chk_out("b2b.run1", 1'b1, 1'b0, held);
    end
    tick();
    held = model_mul(W'(7), W'(9));
    chk_out("b2b.done1", 1'b0, 1'b1, held);
    tick();
    bus.start = 1'b0;
    chk_out("b2b.restart", 1'b1, 1'b0, held);
    repeat (MUL_LATENCY - 1) begin
      tick();
      chk_out("b2b.run2", 1'b1, 1'b0, held);
    end
    tick();
    held = model_mul(W'('h0100), W'('h0100));
    chk_out("b2b.done2", 1'b0, 1'b1, held);
    tick();
    chk_out("b2b.idle", 1'b0, 1'b0, held);

    // Asynchronous reset in the middle of an operation.
    bus.mul1  = W'('h1234);
    bus.mul2  = W'('h5678);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) begin
      tick();
      chk_out("rst_mid.run", 1'b1, 1'b0, held);
    end
    #2;
    rst = 1'b1;
    #1;
    held = '0;
    chk_out("rst_mid.async", 1'b0, 1'b0, held);
    tick();
    tick();
    chk_out("rst_mid.hold", 1'b0, 1'b0, held);
    rst = 1'b0;
    for (int k = 0; k < int'(MUL_LATENCY) + 2; k++) begin
      tick();
      chk_out("rst_mid.no_done", 1'b0, 1'b0, held);
    end
    do_op("after_rst", W'('h1234), W'('h5678), -1);
    chk("after_rst.value", 64'(held), 64'h0626_0060);

    // Random operands, occasionally idling between operations.
    for (int i = 0; i < 20; i++) begin
      do_op("rand", W'($urandom), W'($urandom), -1);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk_out("rand.gap", 1'b0, 1'b0, held);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative radix-2 shift-add unsigned multiplier feeding the ALU's `mulresult` input.
- Consumes the operand magnitudes `mul1`/`mul2`, which the ALU drives in the first execute cycle of MUL/MLA/MLS.
- Returns a 32-bit product after a fixed latency, so the state machine can time `exec2` deterministically.
- Sign handling stays in the ALU; this block is unsigned only.

Parameters:
- WIDTH, 16, operand width; the product is 2*WIDTH bits and latency is WIDTH cycles.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the rising edge in IDLE or DONE.
- mul1  input  WIDTH  multiplicand, unsigned magnitude from the ALU.
- mul2  input  WIDTH  multiplier, unsigned magnitude from the ALU.
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse; `mulresult` is valid and new.
- mulresult  output  2*WIDTH  unsigned product, held until the next completion.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, mulresult=0, internal accumulator/counter=0.
  - Reset mid-operation aborts with no completion pulse.
  - After reset release, the first edge with start=1 begins a fresh operation.
- States:
  - IDLE: busy=0, done=0.
    - start=1 at edge N: latch mcand<=mul1, prod<={WIDTH'0, mul2}, cnt<=0, go to RUN.
  - RUN: busy=1, done=0. Each edge performs one iteration:
    - if prod[0]=1, upper half <= upper + mcand, computed with a WIDTH+1-bit sum to keep the carry;
    - then {carry, upper, lower} shifts right by 1; cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1 (edge N+WIDTH), the final iteration result is written to `mulresult` and state goes to DONE.
    - start is ignored in RUN; operand inputs are not re-sampled.
  - DONE: busy=0, done=1 for exactly one cycle. On the next edge:
    - start=1: behaves as IDLE+start (back-to-back, new operands latched).
    - otherwise: go to IDLE.
- Latency:
  - start sampled at edge N; busy high N..N+WIDTH; done high N+WIDTH..N+WIDTH+1.
  - 16 cycles for WIDTH=16, independent of operand values; no early termination.
- Width/arithmetic rules:
  - The product is exact over the full range; max 0xFFFF*0xFFFF = 0xFFFE0001, with no overflow or truncation.
  - The carry out of each add must feed the shifted-in MSB.
- `mulresult` is stable at all times except the completion edge.
  - It never shows partial products, because internal `prod` is separate from the output register.
- Operand inputs may change freely after the start edge.
- No X on outputs after reset under any input sequence.

Decomposition:
- Shared package (alongside the CPU opcode constants):
  - state enum {IDLE, RUN, DONE};
  - MUL_LATENCY = WIDTH constant, used by the state machine to schedule `exec2`.
- Single module. The per-iteration add/shift is a few lines, so a sub-module is not warranted.
- Counter width is clog2(WIDTH).

Test Plan:
- 3*5: mul1=3, mul2=5, start at edge 0 -> busy cycles 0-15, done=1 exactly at cycle 16, mulresult=0x0000000F, then IDLE.
- Full-scale: 0xFFFF*0xFFFF -> mulresult=0xFFFE0001; 0x8000*0x0002 -> 0x00010000 (carry path).
- Zero and identity: 0x0000*0x1234 -> 0x00000000 after the full 16 cycles; 0x0001*0xABCD -> 0x0000ABCD.
- Start during RUN: 7*9 started, start pulsed with 2*2 at cycle 5 and operand inputs changed -> result 0x0000003F, single done pulse, no second operation.
- Back-to-back: start held high through DONE with new operands 0x0100*0x0100 -> done at cycle 16 (0x3F), second done at cycle 33 (0x00010000); `mulresult` holds 0x3F between the pulses.
- Reset mid-op: assert rst asynchronously at cycle 8 of 0x1234*0x5678 -> busy, done and mulresult go to 0 immediately with no done pulse; a new start of 0x1234*0x5678 after release -> 0x06260060.
